// File: rtl/generation_scheduler_pkg.sv
// Shared types and sizing for the Life generation scheduler.
package generation_scheduler_pkg;

    localparam int unsigned WIDTH_PIXELS    = 6;
    localparam int unsigned HEIGHT_PIXELS   = 6;
    localparam int unsigned SWEEP_CYCLES    = WIDTH_PIXELS * HEIGHT_PIXELS;
    localparam int unsigned SWEEP_CNT_WIDTH = 6;
    localparam int unsigned RD_ADDR_WIDTH   = 6;
    localparam int unsigned RATE_WIDTH      = 8;
    localparam int unsigned GEN_WIDTH       = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_SWEEP = 3'd2,
        ST_SWAP  = 3'd3,
        ST_PACE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_GEN   = 2'd0,
        OP_STEP  = 2'd1,
        OP_CLEAR = 2'd2
    } op_t;

    typedef struct packed {
        logic                     req;
        logic [RD_ADDR_WIDTH-1:0] addr;
    } rd_req_t;

    // A programmed rate of zero still paces one vsync per generation.
    function automatic logic [RATE_WIDTH:0] effective_rate(input logic [RATE_WIDTH-1:0] rate);
        return (rate == '0) ? (RATE_WIDTH+1)'(1) : (RATE_WIDTH+1)'(rate);
    endfunction

endpackage

// File: rtl/generation_scheduler_if.sv
// Displayed-buffer read port shared by scanout, host readback and the memory.
interface generation_scheduler_if;
    import generation_scheduler_pkg::*;

    logic                     disp_rd_req;
    logic [RD_ADDR_WIDTH-1:0] disp_rd_addr;
    logic                     host_rd_req;
    logic [RD_ADDR_WIDTH-1:0] host_rd_addr;
    logic                     host_rd_gnt;
    logic                     mem_rd_en;
    logic [RD_ADDR_WIDTH-1:0] mem_rd_addr;
    logic                     disp_rd_valid;
    logic                     host_rd_valid;

    modport master (
        output disp_rd_req, disp_rd_addr, host_rd_req, host_rd_addr,
        input  host_rd_gnt, mem_rd_en, mem_rd_addr, disp_rd_valid, host_rd_valid
    );

    modport slave (
        input  disp_rd_req, disp_rd_addr, host_rd_req, host_rd_addr,
        output host_rd_gnt, mem_rd_en, mem_rd_addr, disp_rd_valid, host_rd_valid
    );

endinterface

// File: rtl/generation_scheduler_read_port_arbiter.sv
// Fixed-priority (scanout over host) arbiter for the displayed-buffer read port.
module generation_scheduler_read_port_arbiter
    import generation_scheduler_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  stall,
    generation_scheduler_if.slave rd
);

    rd_req_t disp;
    rd_req_t host;
    logic    disp_gnt;
    logic    host_gnt;

    assign disp = {rd.disp_rd_req, rd.disp_rd_addr};
    assign host = {rd.host_rd_req, rd.host_rd_addr};

    assign disp_gnt = disp.req && !stall;
    assign host_gnt = host.req && !disp.req && !stall;

    assign rd.host_rd_gnt = host_gnt;
    assign rd.mem_rd_en   = disp_gnt || host_gnt;
    assign rd.mem_rd_addr = disp.req ? disp.addr : host.addr;

    // Memory returns data one cycle after the grant.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd.disp_rd_valid <= 1'b0;
            rd.host_rd_valid <= 1'b0;
        end else begin
            rd.disp_rd_valid <= disp_gnt;
            rd.host_rd_valid <= host_gnt;
        end
    end

endmodule

// File: rtl/generation_scheduler.sv
// Sequences Life engine sweeps, buffer swaps and vsync pacing; arbitrates buffer reads.
module generation_scheduler
    import generation_scheduler_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_run,
    input  logic                  cmd_step,
    input  logic                  cmd_stop,
    input  logic                  cmd_clear,
    input  logic [RATE_WIDTH-1:0] gen_rate,
    input  logic                  vsync,
    output logic                  engine_resetn,
    output logic                  engine_enable,
    output logic                  engine_clear,
    input  logic                  engine_done,
    output logic                  display_buffer,
    output logic                  running,
    output logic                  busy,
    output logic [GEN_WIDTH-1:0]  gen_count,
    output logic                  sweep_error,
    generation_scheduler_if.slave rd
);

    state_t                     state;
    state_t                     state_nxt;
    op_t                        op;
    op_t                        op_nxt;
    logic                       stop_pending;
    logic                       stop_pending_nxt;
    logic                       running_nxt;
    logic                       buffer_nxt;
    logic                       error_nxt;
    logic [SWEEP_CNT_WIDTH-1:0] sweep_cnt;
    logic [SWEEP_CNT_WIDTH-1:0] sweep_cnt_nxt;
    logic [RATE_WIDTH-1:0]      vsync_cnt;
    logic [RATE_WIDTH-1:0]      vsync_cnt_nxt;
    logic [RATE_WIDTH:0]        vsync_seen;
    logic [GEN_WIDTH-1:0]       gen_nxt;
    logic                       sweep_last;
    logic                       rd_stall;

    assign sweep_last = (sweep_cnt == SWEEP_CNT_WIDTH'(SWEEP_CYCLES - 1));
    assign vsync_seen = (RATE_WIDTH+1)'(vsync_cnt) + (RATE_WIDTH+1)'(1);
    // The displayed buffer flips at the end of SWAP, so no read is granted then.
    assign rd_stall   = (state == ST_SWAP) || !resetn;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        op_nxt           = op;
        stop_pending_nxt = stop_pending;
        running_nxt      = running;
        sweep_cnt_nxt    = sweep_cnt;
        vsync_cnt_nxt    = vsync_cnt;
        buffer_nxt       = display_buffer;
        gen_nxt          = gen_count;
        error_nxt        = sweep_error;

        unique case (state)
            ST_IDLE: begin
                if (!cmd_stop) begin
                    if (cmd_clear) begin
                        op_nxt    = OP_CLEAR;
                        state_nxt = ST_ARM;
                    end else if (cmd_step) begin
                        op_nxt    = OP_STEP;
                        state_nxt = ST_ARM;
                    end else if (cmd_run) begin
                        op_nxt      = OP_GEN;
                        running_nxt = 1'b1;
                        state_nxt   = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                sweep_cnt_nxt = '0;
                state_nxt     = ST_SWEEP;
            end
            ST_SWEEP: begin
                if (engine_done != sweep_last) begin
                    error_nxt = 1'b1;
                end
                if (sweep_last) begin
                    state_nxt = ST_SWAP;
                end else begin
                    sweep_cnt_nxt = sweep_cnt + SWEEP_CNT_WIDTH'(1);
                end
            end
            ST_SWAP: begin
                buffer_nxt    = !display_buffer;
                vsync_cnt_nxt = '0;
                if (op != OP_CLEAR) begin
                    gen_nxt = gen_count + GEN_WIDTH'(1);
                end
                if (stop_pending || cmd_stop || (op != OP_GEN)) begin
                    running_nxt = 1'b0;
                    state_nxt   = ST_IDLE;
                end else begin
                    state_nxt = ST_PACE;
                end
            end
            ST_PACE: begin
                if (cmd_stop) begin
                    state_nxt = ST_IDLE;
                end else if (vsync) begin
                    if (vsync_seen >= effective_rate(gen_rate)) begin
                        state_nxt = ST_ARM;
                    end else begin
                        vsync_cnt_nxt = RATE_WIDTH'(vsync_seen);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A stop never aborts a sweep; it only ends free-run after the next swap.
        if (cmd_stop && (state != ST_IDLE)) begin
            running_nxt      = 1'b0;
            stop_pending_nxt = 1'b1;
        end
        if (state_nxt == ST_IDLE) begin
            stop_pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            op             <= OP_GEN;
            stop_pending   <= 1'b0;
            sweep_cnt      <= '0;
            vsync_cnt      <= '0;
            engine_resetn  <= 1'b0;
            engine_enable  <= 1'b0;
            engine_clear   <= 1'b0;
            display_buffer <= 1'b0;
            running        <= 1'b0;
            busy           <= 1'b0;
            gen_count      <= '0;
            sweep_error    <= 1'b0;
        end else begin
            op             <= op_nxt;
            stop_pending   <= stop_pending_nxt;
            sweep_cnt      <= sweep_cnt_nxt;
            vsync_cnt      <= vsync_cnt_nxt;
            engine_resetn  <= (state_nxt != ST_ARM);
            engine_enable  <= (state_nxt == ST_SWEEP);
            engine_clear   <= (state_nxt == ST_SWEEP) && (op_nxt == OP_CLEAR);
            display_buffer <= buffer_nxt;
            running        <= running_nxt;
            busy           <= (state_nxt != ST_IDLE);
            gen_count      <= gen_nxt;
            sweep_error    <= error_nxt;
        end
    end

    generation_scheduler_read_port_arbiter u_arbiter (
        .clk    (clk),
        .resetn (resetn),
        .stall  (rd_stall),
        .rd     (rd)
    );

endmodule

// File: tb/tb_generation_scheduler.sv
// Directed plus randomized bench for generation_scheduler against a timeline model.
module tb_generation_scheduler;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_run, cmd_step, cmd_stop, cmd_clear;
    logic [7:0]  gen_rate;
    logic        vsync;
    logic        engine_resetn, engine_enable, engine_clear, engine_done;
    logic        display_buffer, running, busy, sweep_error;
    logic [15:0] gen_count;
    logic        disp_req, host_req;
    logic [5:0]  disp_addr, host_addr;
    logic        inj_done;

    generation_scheduler_if rd_if ();

    assign rd_if.disp_rd_req  = disp_req;
    assign rd_if.disp_rd_addr = disp_addr;
    assign rd_if.host_rd_req  = host_req;
    assign rd_if.host_rd_addr = host_addr;

    generation_scheduler dut (
        .clk            (clk),
        .resetn         (resetn),
        .cmd_run        (cmd_run),
        .cmd_step       (cmd_step),
        .cmd_stop       (cmd_stop),
        .cmd_clear      (cmd_clear),
        .gen_rate       (gen_rate),
        .vsync          (vsync),
        .engine_resetn  (engine_resetn),
        .engine_enable  (engine_enable),
        .engine_clear   (engine_clear),
        .engine_done    (engine_done),
        .display_buffer (display_buffer),
        .running        (running),
        .busy           (busy),
        .gen_count      (gen_count),
        .sweep_error    (sweep_error),
        .rd             (rd_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: m_t = cycles since the generation's arm cycle (0 arm, 1..36 sweep, 37 swap),
    // -1 when no generation is in flight; m_wait = counting vsyncs between generations.
    int          m_t    = -1;
    bit          m_wait = 1'b0;
    int          m_vs   = 0;
    int          m_op   = 0;   // 0 free-run, 1 step, 2 clear
    bit          m_run  = 1'b0;
    bit          m_stop = 1'b0;
    bit          m_buf  = 1'b0;
    bit          m_err  = 1'b0;
    bit          m_rst  = 1'b1;
    bit          m_vd   = 1'b0;
    bit          m_vh   = 1'b0;
    logic [15:0] m_gen  = '0;
    bit          e_dgnt, e_hgnt;
    logic        obs_hgnt, obs_en;

    task automatic check_regs();
        bit en;
        en = (m_t >= 1) && (m_t <= 36);
        check_eq("engine_resetn", 32'(engine_resetn), 32'(!m_rst && (m_t != 0)));
        check_eq("engine_enable", 32'(engine_enable), 32'(en));
        check_eq("engine_clear", 32'(engine_clear), 32'(en && (m_op == 2)));
        check_eq("display_buffer", 32'(display_buffer), 32'(m_buf));
        check_eq("running", 32'(running), 32'(m_run));
        check_eq("busy", 32'(busy), 32'((m_t >= 0) || m_wait));
        check_eq("gen_count", 32'(gen_count), 32'(m_gen));
        check_eq("sweep_error", 32'(sweep_error), 32'(m_err));
        check_eq("disp_rd_valid", 32'(rd_if.disp_rd_valid), 32'(m_vd));
        check_eq("host_rd_valid", 32'(rd_if.host_rd_valid), 32'(m_vh));
    endtask

    task automatic check_comb();
        bit stall;
        stall  = (m_t == 37) || !resetn;
        e_dgnt = disp_req && !stall;
        e_hgnt = host_req && !disp_req && !stall;
        obs_hgnt = rd_if.host_rd_gnt;
        obs_en   = rd_if.mem_rd_en;
        check_eq("host_rd_gnt", 32'(rd_if.host_rd_gnt), 32'(e_hgnt));
        check_eq("mem_rd_en", 32'(rd_if.mem_rd_en), 32'(e_dgnt || e_hgnt));
        if (e_dgnt) check_eq("mem_rd_addr_disp", 32'(rd_if.mem_rd_addr), 32'(disp_addr));
        else if (e_hgnt) check_eq("mem_rd_addr_host", 32'(rd_if.mem_rd_addr), 32'(host_addr));
    endtask

    task automatic model_update();
        int rate;
        if (!resetn) begin
            m_t = -1; m_wait = 0; m_vs = 0; m_op = 0; m_run = 0; m_stop = 0;
            m_buf = 0; m_err = 0; m_gen = '0; m_vd = 0; m_vh = 0; m_rst = 1;
            return;
        end
        m_rst = 0;
        m_vd  = e_dgnt;
        m_vh  = e_hgnt;
        rate  = (gen_rate == 8'd0) ? 1 : int'(gen_rate);
        if ((m_t < 0) && !m_wait) begin
            if (cmd_stop) begin
            end else if (cmd_clear) begin m_op = 2; m_t = 0; end
            else if (cmd_step) begin m_op = 1; m_t = 0; end
            else if (cmd_run) begin m_op = 0; m_run = 1; m_t = 0; end
        end else if (m_t >= 0) begin
            if (cmd_stop) begin m_run = 0; m_stop = 1; end
            if ((m_t >= 1) && (m_t <= 36) && (engine_done != (m_t == 36))) m_err = 1;
            if (m_t == 37) begin
                m_buf = !m_buf;
                if (m_op != 2) m_gen = m_gen + 16'd1;
                m_t = -1;
                if (m_stop || (m_op != 0)) begin m_run = 0; m_stop = 0; end
                else begin m_wait = 1; m_vs = 0; end
            end else begin
                m_t++;
            end
        end else begin
            if (cmd_stop) begin
                m_run = 0; m_wait = 0;
            end else if (vsync) begin
                m_vs++;
                if (m_vs >= rate) begin m_wait = 0; m_t = 0; end
            end
        end
    endtask

    // One clock: check state, apply stimulus, check read port, advance model.
    task automatic step_cycle();
        check_regs();
        engine_done = (m_t == 36) || inj_done;
        #1;
        check_comb();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cmd_run = 0; cmd_step = 0; cmd_stop = 0; cmd_clear = 0;
        vsync = 0; inj_done = 0; engine_done = 0;
        if (e_hgnt) host_req = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_n, en_n, lo_n, clr_n;
        logic       buf_before;
        logic [3:0] hist;
        bit         at_swap;

        resetn = 0; cmd_run = 0; cmd_step = 0; cmd_stop = 0; cmd_clear = 0;
        gen_rate = 8'd1; vsync = 0; engine_done = 0; inj_done = 0;
        disp_req = 0; host_req = 0; disp_addr = '0; host_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step_cycle();
        resetn = 1;
        step_cycle();

        // Single step from idle
        cmd_step = 1;
        step_cycle();
        busy_n = 0; en_n = 0; lo_n = 0;
        for (int i = 0; i < 60 && busy; i++) begin
            busy_n++; en_n += int'(engine_enable); lo_n += int'(!engine_resetn);
            step_cycle();
        end
        check_eq("step_busy_cycles", 32'(busy_n), 32'd38);
        check_eq("step_enable_cycles", 32'(en_n), 32'd36);
        check_eq("step_arm_cycles", 32'(lo_n), 32'd1);
        check_eq("step_buffer", 32'(display_buffer), 32'd1);
        check_eq("step_gen", 32'(gen_count), 32'd1);

        // Clear wins over step in the same cycle
        cmd_clear = 1; cmd_step = 1;
        step_cycle();
        clr_n = 0;
        for (int i = 0; i < 60 && busy; i++) begin
            clr_n += int'(engine_clear);
            step_cycle();
        end
        check_eq("clear_cycles", 32'(clr_n), 32'd36);
        check_eq("clear_buffer", 32'(display_buffer), 32'd0);
        check_eq("clear_gen", 32'(gen_count), 32'd1);

        // Free-run at rate 2, vsync in the swap cycle is ignored
        gen_rate = 8'd2; cmd_run = 1;
        step_cycle();
        for (int i = 0; i < 60 && !m_wait; i++) begin
            vsync = (m_t == 37);
            step_cycle();
        end
        vsync = 1;
        step_cycle();
        repeat (3) step_cycle();
        check_eq("pace_hold_resetn", 32'(engine_resetn), 32'd1);
        check_eq("pace_busy", 32'(busy), 32'd1);
        vsync = 1;
        step_cycle();
        check_eq("pace_arm", 32'(engine_resetn), 32'd0);

        // Stop at sweep cycle 10 lets the generation finish
        for (int i = 0; i < 60 && m_t != 11; i++) step_cycle();
        cmd_stop = 1;
        step_cycle();
        check_eq("stop_running", 32'(running), 32'd0);
        check_eq("stop_still_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 60 && busy; i++) step_cycle();
        check_eq("stop_gen", 32'(gen_count), 32'd3);
        check_eq("stop_buffer", 32'(display_buffer), 32'd0);

        // Rate 0 acts as 1; misaligned engine_done latches sweep_error
        gen_rate = 8'd0; cmd_run = 1;
        step_cycle();
        for (int i = 0; i < 60 && !m_wait; i++) begin
            inj_done = (m_t == 21);
            step_cycle();
        end
        check_eq("err_set", 32'(sweep_error), 32'd1);
        vsync = 1;
        step_cycle();
        check_eq("rate0_arm", 32'(engine_resetn), 32'd0);
        for (int i = 0; i < 60 && !m_wait; i++) step_cycle();
        buf_before = display_buffer;
        cmd_stop = 1;
        step_cycle();
        check_eq("pace_stop_busy", 32'(busy), 32'd0);
        check_eq("pace_stop_buffer", 32'(display_buffer), 32'(buf_before));
        check_eq("pace_stop_gen", 32'(gen_count), 32'd5);

        // Scanout reads stall during swap; error stays sticky
        disp_req = 1; cmd_step = 1;
        step_cycle();
        for (int i = 0; i < 60 && busy; i++) begin
            at_swap = (m_t == 37);
            step_cycle();
            if (at_swap) check_eq("swap_stall", 32'(obs_en), 32'd0);
        end
        disp_req = 0;
        check_eq("err_sticky", 32'(sweep_error), 32'd1);

        // Scanout priority: host granted only once scanout drops
        host_req = 1; host_addr = 6'h2A;
        for (int i = 0; i < 4; i++) begin
            disp_req  = (i < 3);
            disp_addr = 6'(i + 5);
            step_cycle();
            hist[i] = obs_hgnt;
        end
        check_eq("host_gnt_pattern", 32'(hist), 32'h8);
        check_eq("host_valid_after", 32'(rd_if.host_rd_valid), 32'd1);

        // Reset mid-sweep
        gen_rate = 8'd1; cmd_run = 1;
        step_cycle();
        for (int i = 0; i < 60 && m_t != 15; i++) step_cycle();
        resetn = 0;
        step_cycle();
        check_eq("rst_enable", 32'(engine_enable), 32'd0);
        check_eq("rst_engine_resetn", 32'(engine_resetn), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_gen", 32'(gen_count), 32'd0);
        check_eq("rst_error", 32'(sweep_error), 32'd0);
        resetn = 1;
        step_cycle();

        // Randomized traffic
        for (int c = 0; c < 6000; c++) begin
            resetn    = ($urandom_range(0, 1499) != 0);
            cmd_run   = ($urandom_range(0, 69) == 0);
            cmd_step  = ($urandom_range(0, 59) == 0);
            cmd_clear = ($urandom_range(0, 149) == 0);
            cmd_stop  = ($urandom_range(0, 119) == 0);
            vsync     = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 99) == 0) gen_rate = 8'($urandom_range(0, 3));
            inj_done  = (m_t >= 1) && (m_t <= 35) && ($urandom_range(0, 499) == 0);
            disp_req  = 1'($urandom_range(0, 1));
            disp_addr = 6'($urandom);
            if (!host_req) begin
                host_req  = ($urandom_range(0, 2) == 0);
                host_addr = 6'($urandom);
            end
            step_cycle();
        end
        check_regs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
